ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch unit for the NPC core; the producer end of the instruction stream that the control unit decodes.
- Holds the PC and issues one request at a time to instruction memory over a valid/ready request channel with a variable-latency response.
- Presents each fetched word to the decode stage with a valid/ready handshake; the top level slices opcode, funct3 and funct7 from it.
- Accepts PC redirects from branch/jump resolution and discards any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address, equal to the current pc.
- imem_resp_valid  in  1  response valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- imem_resp_data  in  XLEN  instruction word.
- imem_resp_err  in  1  access fault for this response.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  XLEN  target PC.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes the instruction.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  PC of inst.
- inst_fault  out  1  fetch fault (bus error or misaligned PC).

Behaviour:
- States: BOOT, REQ, WAIT, DRAIN, HOLD. All outputs are registered or derived from the state only; there are no combinational paths from inputs to outputs.
- Reset: state=BOOT, pc=RESET_PC, inst=0, inst_pc=0, inst_fault=0.
  - During reset: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC.
  - Reset asserted in any state abandons that state. The memory must be reset together with this block.
- BOOT: lasts one cycle, then goes to REQ. Exists so that no request is issued in the first cycle after reset.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, go to WAIT.
  - redirect_valid without a handshake: pc<=redirect_pc and stay in REQ. The address may change while no handshake has occurred; the memory bus permits this.
  - redirect_valid together with a handshake: pc<=redirect_pc and go to DRAIN, because the accepted request is stale.
- WAIT: on imem_resp_valid, capture inst<=imem_resp_data, inst_pc<=pc, inst_fault<=imem_resp_err, then go to HOLD.
  - redirect_valid with no response: pc<=redirect_pc, go to DRAIN.
  - redirect_valid in the same cycle as a response: drop the response, pc<=redirect_pc, go to REQ.
- DRAIN: on imem_resp_valid, discard the response and go to REQ.
  - redirect_valid in DRAIN updates pc and the state stays DRAIN.
- HOLD: inst_valid=1; inst, inst_pc and inst_fault are stable.
  - On inst_ready: pc<=pc+4 (wraps modulo 2^XLEN), go to REQ.
  - redirect_valid: pc<=redirect_pc, go to REQ, instruction dropped. Redirect wins over a simultaneous inst_ready, and pc does not increment.
  - A faulting instruction is handed over like any other and does not stall the unit.
- Misaligned target: when a redirect sets pc with pc[1:0]!=0, the next entry into REQ issues no request. The unit goes directly to HOLD with inst=32'h0000_0013 (NOP), inst_pc=pc, inst_fault=1.
- Latency: request accepted in cycle n, response in cycle n+k (k>=1), inst_valid in cycle n+k+1. Peak throughput is one instruction per 3 cycles with k=1.
- At most one outstanding memory request at any time.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- When defined, adds output ports perf_fetch_cnt (64 bits) and perf_stall_cnt (64 bits), both reset to 0.
  - perf_fetch_cnt increments on every inst_valid&inst_ready handshake.
  - perf_stall_cnt increments every cycle in REQ, WAIT or DRAIN.
  - Both counters wrap.
- When not defined, the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared types header, next to the opcode defines: the state encodings (IFU_BOOT..IFU_HOLD), the NOP constant 32'h0000_0013, and the default reset PC.
- Optional sub-module ifu_perf_cnt: a 64-bit counter with enable. It is instantiated twice and only under IFU_PERF_CNT_EN.

Test Plan:
- Reset release with memory k=1, ready=1 and inst_ready=1:
  - first request in cycle 2 with addr 0x8000_0000;
  - inst_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, one instruction every 3 cycles.
- Memory response at k=5 and inst_ready held low for 4 cycles: inst and inst_pc stay stable, and no new request is issued until the handshake.
- Redirect to 0x8000_0100 while in WAIT: the stale response is discarded, the next request address is 0x8000_0100, and the decoder never sees the old PC.
- Redirect in the same cycle as inst_ready in HOLD: pc becomes the redirect target, not pc+4.
- Redirect to 0x8000_0102: no memory request; inst=0x0000_0013, inst_fault=1, inst_pc=0x8000_0102.
- imem_resp_err=1: inst_fault=1 with the returned data, and the next fetch is at pc+4. With IFU_PERF_CNT_EN defined, check the counter values against cycle counts.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage types: FSM state encodings, the NOP word injected on
// misaligned fetches, and the default reset PC.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    IFU_BOOT  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_DRAIN = 3'd3,
    IFU_HOLD  = 3'd4
  } ifu_state_e;

  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// 64-bit wrapping event counter with enable, used for fetch statistics.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= cnt + 64'd1;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, decode-side valid/ready,
// redirect with stale-response drain. Define IFU_PERF_CNT_EN for perf counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  ifu_state_e      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, inst_nxt, inst_pc_nxt;
  logic            fault_nxt;
  logic            misaligned;

  // A misaligned pc never reaches the bus; REQ turns it into a faulting NOP.
  assign misaligned     = pc[1:0] != 2'b00;
  assign imem_req_valid = (state == IFU_REQ) && !misaligned;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == IFU_HOLD);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    fault_nxt   = inst_fault;
    unique case (state)
      IFU_BOOT: state_nxt = IFU_REQ;
      IFU_REQ: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = (imem_req_valid && imem_req_ready) ? IFU_DRAIN : IFU_REQ;
        end else if (misaligned) begin
          inst_nxt    = XLEN'(IFU_NOP);
          inst_pc_nxt = pc;
          fault_nxt   = 1'b1;
          state_nxt   = IFU_HOLD;
        end else if (imem_req_ready) begin
          state_nxt = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          // With a response this cycle it is simply dropped; otherwise drain it later.
          pc_nxt    = redirect_pc;
          state_nxt = imem_resp_valid ? IFU_REQ : IFU_DRAIN;
        end else if (imem_resp_valid) begin
          inst_nxt    = imem_resp_data;
          inst_pc_nxt = pc;
          fault_nxt   = imem_resp_err;
          state_nxt   = IFU_HOLD;
        end
      end
      IFU_DRAIN: begin
        if (redirect_valid)  pc_nxt    = redirect_pc;
        if (imem_resp_valid) state_nxt = IFU_REQ;
      end
      IFU_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = IFU_REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + XLEN'(4);
          state_nxt = IFU_REQ;
        end
      end
      default: state_nxt = IFU_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IFU_BOOT;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_fault <= fault_nxt;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic stall_en;
  assign stall_en = (state == IFU_REQ) || (state == IFU_WAIT) || (state == IFU_DRAIN);

  ifu_perf_cnt u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .en  (inst_valid && inst_ready),
    .cnt (perf_fetch_cnt)
  );

  ifu_perf_cnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .cnt (perf_stall_cnt)
  );
`endif

endmodule
